// File: rtl/resource_scoreboard.sv
// Multi-bank memory/accelerator scoreboard with round-robin bank allocation.
// Optional per-bank watchdog reclaim is enabled by defining SCOREBOARD_TIMEOUT_EN.
module resource_scoreboard #(
    parameter int                           SRC_ID_W              = 4,
    parameter int                           OPCODE_W              = 2,
    parameter int                           NUM_MEM               = 2,
    parameter int                           NUM_ACCEL             = 2,
    parameter logic [NUM_MEM*SRC_ID_W-1:0]  MEM_RES_SRC_IDS       = '0,
    parameter logic [NUM_ACCEL*SRC_ID_W-1:0] ACCEL_RES_SRC_IDS    = '0,
    parameter logic [NUM_ACCEL*SRC_ID_W-1:0] ACCEL_FSM_SRC_IDS    = '0,
    parameter int                           TIMEOUT_CYCLES        = 200,
    parameter int                           TIMEOUT_W             = 8,
    parameter logic [OPCODE_W-1:0]          MEM_OPCODE_READ       = 0,
    parameter logic [OPCODE_W-1:0]          MEM_OPCODE_WRITE_ADDR = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [SRC_ID_W-1:0]          req_src_id,
    input  logic [OPCODE_W-1:0]          req_opcode,
    input  logic                         ack_valid,
    input  logic [SRC_ID_W-1:0]          ack_src_id,
    output logic                         out_valid,
    output logic [SRC_ID_W-1:0]          out_mem_id,
    output logic [SRC_ID_W-1:0]          out_accel_id,
    output logic                         mem_ready,
    output logic [$clog2(NUM_MEM+1)-1:0] busy_count,
    output logic                         timeout_valid,
    output logic [SRC_ID_W-1:0]          timeout_mem_id
);

    localparam int CNT_W = $clog2(NUM_MEM + 1);
    localparam int IDX_W = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        HELD   = 2'd1,
        LOCKED = 2'd2,
        DRAIN  = 2'd3
    } bankState_t;

    bankState_t            bankState_q [NUM_MEM];
    bankState_t            bankState_d [NUM_MEM];
    logic [SRC_ID_W-1:0]   ownerId_q   [NUM_MEM];
    logic [SRC_ID_W-1:0]   ownerId_d   [NUM_MEM];
    logic [SRC_ID_W-1:0]   accelId_q   [NUM_MEM];
    logic [SRC_ID_W-1:0]   accelId_d   [NUM_MEM];
    logic [NUM_MEM-1:0]    ackHit;
    logic [IDX_W-1:0]      rrPtr_q, rrPtr_d;
    logic [CNT_W-1:0]      busyCount_q, busyCount_d;
    logic                  outValid_q, outValid_d;
    logic [SRC_ID_W-1:0]   outMemId_q, outMemId_d;
    logic [SRC_ID_W-1:0]   outAccelId_q, outAccelId_d;

    logic                  isMemOp, anyFree, accept, memGrant, accelGrant;
    logic                  accelMapped, grantFound, drainFreed;
    logic [SRC_ID_W-1:0]   boundAccel;
    logic [IDX_W-1:0]      grantIdx, cand;
    logic                  tmoFire;
    logic [IDX_W-1:0]      tmoIdx;

    function automatic logic [SRC_ID_W-1:0] memResId(input int idx);
        return MEM_RES_SRC_IDS[idx*SRC_ID_W +: SRC_ID_W];
    endfunction

    always_comb begin
        isMemOp = (req_opcode == MEM_OPCODE_READ) || (req_opcode == MEM_OPCODE_WRITE_ADDR);
        anyFree = 1'b0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (bankState_q[i] == FREE) anyFree = 1'b1;
        end
        accelMapped = 1'b0;
        boundAccel  = '0;
        for (int i = 0; i < NUM_ACCEL; i++) begin
            if (!accelMapped && (ACCEL_FSM_SRC_IDS[i*SRC_ID_W +: SRC_ID_W] == req_src_id)) begin
                accelMapped = 1'b1;
                boundAccel  = ACCEL_RES_SRC_IDS[i*SRC_ID_W +: SRC_ID_W];
            end
        end
        // Round-robin: scan starting one past the last granted bank.
        grantFound = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_MEM; k++) begin
            cand = IDX_W'((int'(rrPtr_q) + k) % NUM_MEM);
            if (!grantFound && (bankState_q[cand] == FREE)) begin
                grantFound = 1'b1;
                grantIdx   = cand;
            end
        end
    end

    assign mem_ready  = anyFree;
    assign req_ready  = !isMemOp || anyFree;
    assign accept     = req_valid && req_ready;
    assign memGrant   = accept && isMemOp && grantFound;
    assign accelGrant = accept && !isMemOp && accelMapped;

`ifdef SCOREBOARD_TIMEOUT_EN
    logic [TIMEOUT_W-1:0]  tmoCnt_q [NUM_MEM];
    logic [TIMEOUT_W-1:0]  tmoCnt_d [NUM_MEM];
    logic                  timeoutValid_q;
    logic [SRC_ID_W-1:0]   timeoutMemId_q;

    always_comb begin
        tmoFire = 1'b0;
        tmoIdx  = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (!tmoFire && (bankState_q[i] != FREE) && !ackHit[i] &&
                (tmoCnt_q[i] >= TIMEOUT_W'(TIMEOUT_CYCLES))) begin
                tmoFire = 1'b1;
                tmoIdx  = IDX_W'(i);
            end
        end
    end

    // Counters hold at the limit so losers of a same-cycle expiry fire later.
    always_comb begin
        for (int i = 0; i < NUM_MEM; i++) begin
            tmoCnt_d[i] = tmoCnt_q[i];
            if ((bankState_d[i] == FREE) || (bankState_d[i] != bankState_q[i])) begin
                tmoCnt_d[i] = '0;
            end else if (tmoCnt_q[i] < TIMEOUT_W'(TIMEOUT_CYCLES)) begin
                tmoCnt_d[i] = tmoCnt_q[i] + TIMEOUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MEM; i++) tmoCnt_q[i] <= '0;
            timeoutValid_q <= 1'b0;
            timeoutMemId_q <= '0;
        end else begin
            for (int i = 0; i < NUM_MEM; i++) tmoCnt_q[i] <= tmoCnt_d[i];
            timeoutValid_q <= tmoFire;
            timeoutMemId_q <= tmoFire ? memResId(int'(tmoIdx)) : '0;
        end
    end

    assign timeout_valid  = timeoutValid_q;
    assign timeout_mem_id = timeoutMemId_q;
`else
    assign tmoFire        = 1'b0;
    assign tmoIdx         = '0;
    assign timeout_valid  = 1'b0;
    assign timeout_mem_id = '0;
`endif

    always_comb begin
        drainFreed = 1'b0;
        for (int i = 0; i < NUM_MEM; i++) begin
            bankState_d[i] = bankState_q[i];
            ownerId_d[i]   = ownerId_q[i];
            accelId_d[i]   = accelId_q[i];
            ackHit[i]      = 1'b0;
        end
        // Only the lowest-indexed DRAIN bank bound to the acking accelerator frees.
        for (int i = 0; i < NUM_MEM; i++) begin
            if (ack_valid) begin
                case (bankState_q[i])
                    HELD: begin
                        if (ack_src_id == memResId(i)) begin
                            bankState_d[i] = FREE;
                            ackHit[i]      = 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (ack_src_id == memResId(i)) begin
                            bankState_d[i] = (accelId_q[i] == '0) ? FREE : DRAIN;
                            ackHit[i]      = 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (!drainFreed && (ack_src_id == accelId_q[i])) begin
                            bankState_d[i] = FREE;
                            ackHit[i]      = 1'b1;
                            drainFreed     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (tmoFire) bankState_d[tmoIdx] = FREE;
        if (memGrant) begin
            bankState_d[grantIdx] = (req_opcode == MEM_OPCODE_READ) ? HELD : LOCKED;
            ownerId_d[grantIdx]   = req_src_id;
            accelId_d[grantIdx]   = (req_opcode == MEM_OPCODE_READ) ? '0
                                  : (accelMapped ? boundAccel : '0);
        end
    end

    always_comb begin
        busyCount_d = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (bankState_d[i] != FREE) busyCount_d = busyCount_d + CNT_W'(1);
        end
        rrPtr_d      = memGrant ? grantIdx : rrPtr_q;
        outValid_d   = memGrant || accelGrant;
        outMemId_d   = memGrant ? memResId(int'(grantIdx)) : '0;
        outAccelId_d = accelGrant ? boundAccel : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MEM; i++) begin
                bankState_q[i] <= FREE;
                ownerId_q[i]   <= '0;
                accelId_q[i]   <= '0;
            end
            rrPtr_q      <= IDX_W'(NUM_MEM - 1);
            busyCount_q  <= '0;
            outValid_q   <= 1'b0;
            outMemId_q   <= '0;
            outAccelId_q <= '0;
        end else begin
            for (int i = 0; i < NUM_MEM; i++) begin
                bankState_q[i] <= bankState_d[i];
                ownerId_q[i]   <= ownerId_d[i];
                accelId_q[i]   <= accelId_d[i];
            end
            rrPtr_q      <= rrPtr_d;
            busyCount_q  <= busyCount_d;
            outValid_q   <= outValid_d;
            outMemId_q   <= outMemId_d;
            outAccelId_q <= outAccelId_d;
        end
    end

    assign out_valid    = outValid_q;
    assign out_mem_id   = outMemId_q;
    assign out_accel_id = outAccelId_q;
    assign busy_count   = busyCount_q;

endmodule
